// File: rtl/data_mem_access_if.sv
// Bus between the execute stage and the memory unit.
// master (pipeline side): drives valid/uop/addr/wdata and the raw gpio_in pins.
// slave  (data_mem_access): returns d_cache, gpio_state, gpio_out, stall, load_done.
interface data_mem_access_if #(
  parameter int GPIO_WIDTH = 8
);
  logic                  valid;
  logic [4:0]            uop;
  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic [GPIO_WIDTH-1:0] gpio_in;
  logic [31:0]           d_cache;
  logic [31:0]           gpio_state;
  logic [GPIO_WIDTH-1:0] gpio_out;
  logic                  stall;
  logic                  load_done;

  modport master (
    output valid, uop, addr, wdata, gpio_in,
    input  d_cache, gpio_state, gpio_out, stall, load_done
  );

  modport slave (
    input  valid, uop, addr, wdata, gpio_in,
    output d_cache, gpio_state, gpio_out, stall, load_done
  );
endinterface

// File: rtl/data_mem_access.sv
// Execute-stage memory unit: data RAM, GPIO output register, GPIO input
// synchronizer. Services LDR/STR and stalls one cycle on RAM loads because
// the RAM read is registered.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active high
//   bus  - data_mem_access_if.slave (uop/addr/wdata/gpio_in in,
//          d_cache/gpio_state/gpio_out/stall/load_done out)
module data_mem_access #(
  parameter int DEPTH      = 31,
  parameter int GPIO_ADDR  = 32,
  parameter int GPIO_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_access_if.slave    bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] UOP_LDR = 5'd10;
  localparam logic [4:0] UOP_STR = 5'd11;

  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nxt;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           d_cache;
  logic [GPIO_WIDTH-1:0] gpio_out;
  logic [GPIO_WIDTH-1:0] sync1, sync2;
  logic                  stall, load_done;

  logic is_ram, is_gpio, is_ldr, is_str;
  logic ld_ram, st_ram, st_gpio;
  logic [AW-1:0] idx;

  assign is_ram  = bus.addr < 32'(DEPTH);
  assign is_gpio = bus.addr == 32'(GPIO_ADDR);
  assign is_ldr  = bus.valid && (bus.uop == UOP_LDR);
  assign is_str  = bus.valid && (bus.uop == UOP_STR);
  assign idx     = bus.addr[AW-1:0];

  // Requests are only acted on in IDLE; in RESP the held pipeline is still
  // presenting the same LDR, so inputs are ignored.
  assign ld_ram  = (state == IDLE) && is_ldr && is_ram;
  assign st_ram  = (state == IDLE) && is_str && is_ram;
  assign st_gpio = (state == IDLE) && is_str && is_gpio;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    stall     = 1'b0;
    load_done = 1'b0;
    case (state)
      IDLE: begin
        if (ld_ram) begin
          stall     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && st_ram) mem[idx] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_cache  <= '0;
      gpio_out <= '0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      if (ld_ram)  d_cache  <= mem[idx];
      if (st_gpio) gpio_out <= bus.wdata[GPIO_WIDTH-1:0];
      sync1 <= bus.gpio_in;
      sync2 <= sync1;
    end
  end

  assign bus.d_cache    = d_cache;
  assign bus.gpio_out   = gpio_out;
  assign bus.gpio_state = 32'(sync2);
  assign bus.stall      = stall;
  assign bus.load_done  = load_done;
endmodule

// File: tb/tb_data_mem_access.sv
module tb_data_mem_access;
  localparam int DEPTH = 31;
  localparam int GA    = 32;
  localparam int GW    = 8;
  localparam logic [4:0] LDR = 5'd10;
  localparam logic [4:0] STR = 5'd11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_access_if #(.GPIO_WIDTH(GW)) bus();

  data_mem_access #(.DEPTH(DEPTH), .GPIO_ADDR(GA), .GPIO_WIDTH(GW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic          stall;
    logic          ld;
    logic [31:0]   dc;
    logic [31:0]   gs;
    logic [GW-1:0] go;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: memory contents, pending-load flag, last load value,
  // GPIO output register and the last two sampled pin vectors.
  logic [31:0]   mmem [DEPTH];
  logic          pend;
  logic [31:0]   mdc;
  logic [GW-1:0] mgo;
  logic [GW-1:0] h1, h2;
  logic          init = 1'b0;
  logic [GW-1:0] gpin = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus: drive just after the edge, record what the
  // outputs must show during this cycle, then advance the model past the
  // edge that closes the cycle.
  task automatic cyc(input logic r, input logic v, input logic [4:0] u,
                     input logic [31:0] a, input logic [31:0] w, output logic st);
    exp_t e;
    @(posedge clk); #1;
    rst = r; bus.valid = v; bus.uop = u; bus.addr = a; bus.wdata = w; bus.gpio_in = gpin;
    e.stall = !pend && v && (u == LDR) && (a < DEPTH);
    e.ld    = pend;
    e.dc    = mdc;
    e.go    = mgo;
    e.gs    = 32'(h2);
    st      = e.stall;
    if (init) q.push_back(e);
    if (r) begin
      pend = 1'b0; mdc = '0; mgo = '0; h1 = '0; h2 = '0; init = 1'b1;
    end else begin
      if (pend) pend = 1'b0;
      else if (v && u == LDR && a < DEPTH) begin mdc = mmem[a]; pend = 1'b1; end
      else if (v && u == STR && a < DEPTH) mmem[a] = w;
      else if (v && u == STR && a == GA)   mgo = w[GW-1:0];
      h2 = h1; h1 = gpin;
    end
  endtask

  // Present an instruction; a stalled one is held for the extra cycle.
  task automatic issue(input logic v, input logic [4:0] u, input logic [31:0] a, input logic [31:0] w);
    logic st, st2;
    cyc(1'b0, v, u, a, w, st);
    if (st) cyc(1'b0, v, u, a, w, st2);
  endtask

  task automatic idle();
    logic st;
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, st);
  endtask

  // Monitor: pops one expectation per cycle, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("stall",      32'(bus.stall),     32'(e.stall));
        chk("load_done",  32'(bus.load_done), 32'(e.ld));
        chk("d_cache",    bus.d_cache,        e.dc);
        chk("gpio_out",   32'(bus.gpio_out),  32'(e.go));
        chk("gpio_state", bus.gpio_state,     e.gs);
      end
    end
  end

  initial begin
    logic st;
    logic [4:0] u;
    logic [31:0] a;
    rst = 1'b1; bus.valid = 1'b0; bus.uop = '0; bus.addr = '0; bus.wdata = '0; bus.gpio_in = '0;
    pend = 1'b0; mdc = '0; mgo = '0; h1 = '0; h2 = '0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;

    cyc(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, st);
    idle();
    for (int i = 0; i < DEPTH; i++) issue(1'b1, STR, 32'(i), $urandom);

    // store then load
    issue(1'b1, STR, 32'd5, 32'hDEADBEEF);
    issue(1'b1, LDR, 32'd5, 32'd0);
    chk("ldr5_data", bus.d_cache, 32'hDEADBEEF);
    chk("ldr5_done", 32'(bus.load_done), 32'd1);

    // GPIO store
    issue(1'b1, STR, 32'd32, 32'h1234_56A5);
    idle();
    chk("gpio_out_a5", 32'(bus.gpio_out), 32'h0000_00A5);
    issue(1'b1, LDR, 32'd0, 32'd0);

    // synchronizer latency
    gpin = 8'h00; idle(); idle(); idle();
    gpin = 8'h3C; idle();
    idle(); chk("gs_1edge", bus.gpio_state, 32'h0);
    idle(); chk("gs_2edge", bus.gpio_state, 32'h0000_003C);

    // boundaries
    issue(1'b1, STR, 32'd30, 32'd7);
    issue(1'b1, LDR, 32'd30, 32'd0);
    chk("ldr30", bus.d_cache, 32'd7);
    issue(1'b1, STR, 32'd31, 32'hFFFF_FFFF);
    issue(1'b1, STR, 32'd40, 32'hFFFF_FFFF);
    issue(1'b1, LDR, 32'd31, 32'd0);
    chk("ldr31_keep", bus.d_cache, 32'd7);
    chk("gpio_keep", 32'(bus.gpio_out), 32'h0000_00A5);

    // back-to-back loads
    issue(1'b1, STR, 32'd1, 32'd11);
    issue(1'b1, STR, 32'd2, 32'd22);
    issue(1'b1, LDR, 32'd1, 32'd0);
    chk("b2b_1", bus.d_cache, 32'd11);
    issue(1'b1, LDR, 32'd2, 32'd0);
    chk("b2b_2", bus.d_cache, 32'd22);

    // reset in the RESP cycle
    cyc(1'b0, 1'b1, LDR, 32'd3, 32'd0, st);
    cyc(1'b1, 1'b1, LDR, 32'd3, 32'd0, st);
    idle();
    chk("rst_resp_dc", bus.d_cache, 32'd0);
    chk("rst_resp_ld", 32'(bus.load_done), 32'd0);
    issue(1'b1, LDR, 32'd2, 32'd0);
    chk("post_rst_ldr", bus.d_cache, 32'd22);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) gpin = GW'($urandom);
      case ($urandom_range(0, 3))
        0, 1: u = LDR;
        2:    u = STR;
        default: u = 5'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       a = 32'd32;
        1:       a = $urandom;
        2:       a = 32'($urandom_range(31, 40));
        default: a = 32'($urandom_range(0, DEPTH - 1));
      endcase
      if ($urandom_range(0, 59) == 0) cyc(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, st);
      else issue($urandom_range(0, 4) != 0, u, a, $urandom);
    end

    idle(); idle();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_access.md
Name: data_mem_access

Overview:
Execute-stage memory unit that sits directly upstream of the register return mux. It owns the data RAM, the GPIO output register and the GPIO input synchronizer. It services LDR/STR uops and produces the d_cache and gpio_state words that the return mux selects between. It stalls the pipeline for one cycle on RAM loads, because the RAM has a registered read.

Parameters:
DEPTH, 31, number of 32-bit RAM words; valid RAM addresses are 0..DEPTH-1
GPIO_ADDR, 32, word address of the GPIO register
GPIO_WIDTH, 8, number of GPIO pins (1..32)

Ports:
clk  input  1  system clock; everything is sampled on the rising edge
rst  input  1  synchronous reset, active-high
valid  input  1  the uop/addr/wdata fields hold a live instruction this cycle
uop  input  5  micro-op; 5'd10 = LDR, 5'd11 = STR, all other codes are no memory action
addr  input  32  word address (ALU result)
wdata  input  32  store data
gpio_in  input  GPIO_WIDTH  asynchronous external pin levels
d_cache  output  32  RAM load data, to the return mux
gpio_state  output  32  synchronized pin levels, zero-extended, to the return mux
gpio_out  output  GPIO_WIDTH  GPIO output register
stall  output  1  hold the pipeline (do not advance the uop) this cycle
load_done  output  1  d_cache holds fresh data for the current LDR this cycle

Behaviour:
- Reset: one clk edge with rst=1 produces the following state.
  - FSM state = IDLE.
  - d_cache = 0, gpio_out = 0.
  - Both synchronizer stages = 0, so gpio_state = 0.
  - stall = 0, load_done = 0.
  - RAM contents are not reset and are undefined until written.
- rst has priority over every other input. A reset during RESP aborts the load: the next cycle is IDLE with stall=0 and load_done=0.
- Address classes:
  - RAM: addr < DEPTH (unsigned, full 32 bits).
  - GPIO: addr == GPIO_ADDR.
  - All other addresses are unmapped.
- FSM, IDLE state:
  - stall = valid && uop==LDR && RAM-class (combinational, same cycle).
  - When stall is asserted, the RAM read of addr[4:0] is issued. At the edge, d_cache <= RAM[addr] and the state moves to RESP.
  - Otherwise the FSM stays in IDLE.
- FSM, RESP state:
  - stall = 0, load_done = 1.
  - d_cache is stable so the return mux and register file capture it this cycle.
  - All inputs are ignored, because the same LDR is still presented by the held pipeline.
  - The FSM returns to IDLE unconditionally.
- LDR latency: 2 cycles from presentation to writeback, with exactly 1 stall cycle.
- Back-to-back RAM LDRs repeat the IDLE -> RESP sequence; no request is lost.
- LDR to the GPIO class or an unmapped address:
  - No stall and no FSM change.
  - d_cache is unchanged; the return mux supplies gpio_state or zero.
- STR (single cycle, no stall, accepted only in IDLE):
  - RAM class: RAM[addr] <= wdata at the edge.
  - GPIO class: gpio_out <= wdata[GPIO_WIDTH-1:0].
  - Unmapped: no effect.
- A load from the same address on the following cycle returns the newly stored value (write-first by construction; no same-cycle read/write case exists).
- d_cache holds its last load value until the next RAM LDR completes.
- gpio_state:
  - Two-flop synchronizer on gpio_in.
  - gpio_state = {zeros, sync2}.
  - Latency: a pin change is visible 2 edges later.
- valid=0, or any uop other than LDR/STR: no state change, stall = 0.

Test Plan:
- Reset, then STR addr=5 wdata=32'hDEADBEEF, then LDR addr=5 -> stall=1 for exactly 1 cycle; next cycle load_done=1 and d_cache=32'hDEADBEEF.
- STR addr=32 wdata=32'h1234_56A5 -> gpio_out=8'hA5 after the edge; stall stays 0; the RAM is untouched (LDR addr=0 still returns its prior value).
- Drive gpio_in 8'h00 -> 8'h3C -> gpio_state=32'h0000_003C after exactly 2 edges, not 1.
- Boundaries: STR addr=30 wdata=7 then LDR 30 -> 7; STR addr=31 and addr=40 -> no RAM write and no gpio_out change; LDR addr=31 -> stall=0 and d_cache unchanged.
- Back-to-back LDR 1, LDR 2 (RAM 1=11, 2=22) -> stall pattern 1,0,1,0; d_cache 11 then 22; load_done pulses twice.
- Assert rst during the RESP cycle of an LDR -> next cycle stall=0, load_done=0, d_cache=0, gpio_out=0; a subsequent LDR behaves normally.
